// File: rtl/rgbled_ctrl.sv
// WS281x chain sequencer: pending/active colour buffers, a one-deep command latch,
// and a frame streamer feeding ws281x_drv over its go/valid/last/ack handshake.
module rgbled_ctrl #(
   parameter int NumLeds = 2,
   parameter int IdxW    = (NumLeds > 1) ? $clog2(NumLeds) : 1
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            wr_en_i,
   input  logic [IdxW-1:0] wr_idx_i,
   input  logic [23:0]     wr_data_i,
   input  logic            update_i,
   input  logic            off_i,
   output logic            busy_o,
   output logic            done_o,
   output logic            drv_go_o,
   output logic [23:0]     drv_data_o,
   output logic            drv_valid_o,
   output logic            drv_last_o,
   input  logic            drv_ack_i,
   input  logic            drv_idle_i
);

   typedef enum logic [1:0] {IDLE, SEND, WAIT_IDLE} state_t;
   typedef enum logic [1:0] {CMD_NONE, CMD_UPD, CMD_OFF} cmd_t;

   state_t                   state_q, state_d;
   cmd_t                     cmd_q;
   logic [IdxW-1:0]          idx_q;
   logic                     zero_q, done_q;
   logic [NumLeds-1:0][23:0] pend_q, act_q;
   logic [23:0]              cur;
   logic                     is_last, start;

   assign is_last = (idx_q == IdxW'(NumLeds - 1));
   assign start   = (state_q == IDLE) && (cmd_q != CMD_NONE);

   // Explicit compare-mux keeps the select legal when IdxW is wider than needed.
   always_comb begin
      cur = '0;
      for (int i = 0; i < NumLeds; i++)
         if (idx_q == IdxW'(i)) cur = act_q[i];
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pend_q <= '0;
         act_q  <= '0;
         cmd_q  <= CMD_NONE;
         zero_q <= 1'b0;
         idx_q  <= '0;
         done_q <= 1'b0;
      end else begin
         // Out-of-range indices match no entry and are dropped.
         for (int i = 0; i < NumLeds; i++)
            if (wr_en_i && (wr_idx_i == IdxW'(i))) pend_q[i] <= wr_data_i;

         // A fresh pulse overwrites the latch, even in the cycle it is consumed.
         if (off_i)         cmd_q <= CMD_OFF;
         else if (update_i) cmd_q <= CMD_UPD;
         else if (start)    cmd_q <= CMD_NONE;

         if (start) begin
            idx_q  <= '0;
            zero_q <= (cmd_q == CMD_OFF);
            if (cmd_q == CMD_UPD) act_q <= pend_q;
         end else if ((state_q == SEND) && drv_ack_i && !is_last) begin
            idx_q <= idx_q + IdxW'(1);
         end

         done_q <= (state_q == WAIT_IDLE) && drv_idle_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d     = state_q;
      drv_go_o    = 1'b0;
      drv_valid_o = 1'b0;
      drv_last_o  = 1'b0;
      drv_data_o  = '0;
      unique case (state_q)
         IDLE: if (start) state_d = SEND;
         SEND: begin
            drv_go_o    = 1'b1;
            drv_valid_o = 1'b1;
            drv_last_o  = is_last;
            drv_data_o  = zero_q ? 24'h0 : {cur[15:8], cur[23:16], cur[7:0]};
            if (drv_ack_i && is_last) state_d = WAIT_IDLE;
         end
         WAIT_IDLE: if (drv_idle_i) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign busy_o = (state_q != IDLE);
   assign done_o = done_q;

endmodule
